// File: rtl/lcd_char_writer.sv
// -----------------------------------------------------------------------------
// lcd_char_writer
//
// Output-side transmitter for the calculator's HD44780-style character LCD.
// After reset it idles for the power-up delay and then sends the fixed init
// sequence 0x38, 0x0C, 0x06, 0x01 as commands. After that it accepts one
// character or command per valid/ready handshake. Each transfer is sent as
// SETUP -> E_HIGH -> HOLD -> WAIT, with every phase timed by a cycle-count
// parameter. The block also keeps track of the cursor cell.
//
// Optional feature (compile-time macro LCD_AUTOWRAP_EN):
//   defined   - a data write that runs past column 15 is followed by an
//               internal set-DDRAM command (0xC0 or 0x80). This command moves
//               the cursor to column 0 of the other line. wr_ready stays low
//               until that command has finished.
//   undefined - no command is inserted. The tracked column wraps from 15 to 0
//               on the same line.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   wr_valid   write request from the display logic
//   wr_rs      0 = command, 1 = character data
//   wr_data    command or character byte
//   wr_ready   a write can be accepted in this cycle (IDLE and init done)
//   init_done  init sequence has completed; stays set until rst
//   cur_pos    {line, col[3:0]} of the next character cell
//   lcd_e      LCD enable strobe
//   lcd_rs     LCD register select
//   lcd_rw     LCD read/write; tied to write (0)
//   lcd_data   LCD data bus
// -----------------------------------------------------------------------------
module lcd_char_writer #(
    parameter int POWERUP_CYC    = 1500000,
    parameter int SETUP_CYC      = 4,
    parameter int E_PULSE_CYC    = 25,
    parameter int HOLD_CYC       = 4,
    parameter int CMD_WAIT_CYC   = 4000,
    parameter int CLEAR_WAIT_CYC = 160000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       init_done,
    output logic [4:0] cur_pos,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The counter only ever holds N-1 down to 0, so log2 of the largest count
    // gives enough bits.
    localparam int MAX_CYC = max2(max2(max2(POWERUP_CYC, SETUP_CYC),
                                       max2(E_PULSE_CYC, HOLD_CYC)),
                                  max2(CMD_WAIT_CYC, CLEAR_WAIT_CYC));
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // Each phase loads N-1 and leaves the phase on the cycle the counter is 0,
    // so a phase of N lasts exactly N cycles.
    localparam logic [CNT_W-1:0] POWERUP_LD = CNT_W'(POWERUP_CYC - 1);
    localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] E_LD       = CNT_W'(E_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LD     = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLEAR_LD   = CNT_W'(CLEAR_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    localparam logic [1:0] INIT_LAST = 2'd3;

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_INIT_LOAD,
        ST_SETUP,
        ST_E_HIGH,
        ST_HOLD,
        ST_WAIT,
        ST_WRAP_LOAD,
        ST_IDLE
    } state_t;

    // NOTE: the init bytes come from a constant lookup and are not stored in a
    // register array, so there is no storage that needs a reset.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = 8'h38;   // 8-bit bus, 2 lines, 5x8 font
            2'd1:    b = 8'h0C;   // display on, cursor off
            2'd2:    b = 8'h06;   // entry mode: increment, no shift
            default: b = 8'h01;   // clear display
        endcase
        return b;
    endfunction

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       init_idx;

    logic             is_clear_cmd;
    logic [4:0]       pos_next;
`ifdef LCD_AUTOWRAP_EN
    logic             wrap_next;
`endif

    assign lcd_rw = 1'b0;

    // The bus keeps the byte of the transfer in progress. It therefore gives
    // both the length of the wait and the cursor update, and no copy of the
    // byte is needed.
    assign is_clear_cmd = !lcd_rs && ((lcd_data == 8'h01) || (lcd_data == 8'h02));

    // Cursor position after the transfer that is now on the bus.
    always_comb begin
        // NOTE: every signal of this block gets a default first. No path can
        // leave one unassigned, so no latch is inferred.
        pos_next = cur_pos;
`ifdef LCD_AUTOWRAP_EN
        wrap_next = 1'b0;
`endif
        if (lcd_rs) begin
`ifdef LCD_AUTOWRAP_EN
            // Past column 15 the position is left unchanged. The inserted
            // 0xC0/0x80 command sets it through the set-DDRAM rule below.
            if (cur_pos[3:0] == 4'hF) begin
                wrap_next = 1'b1;
            end else begin
                pos_next = {cur_pos[4], cur_pos[3:0] + 4'd1};
            end
`else
            // The 4-bit column rolls 15 -> 0 on the same line.
            pos_next = {cur_pos[4], cur_pos[3:0] + 4'd1};
`endif
        end else if (is_clear_cmd) begin
            pos_next = 5'd0;
        end else if (lcd_data[7]) begin
            pos_next = {lcd_data[6], lcd_data[3:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: state and outputs use non-blocking assignments. Every
            // register then samples values from before the edge, whatever the
            // order of the statements.
            state     <= ST_POWERUP;
            cnt       <= POWERUP_LD;
            init_idx  <= 2'd0;
            wr_ready  <= 1'b0;
            init_done <= 1'b0;
            cur_pos   <= 5'd0;
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= 8'h00;
        end else begin
            case (state)
                ST_POWERUP: begin
                    if (cnt == '0) begin
                        state <= ST_INIT_LOAD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                ST_INIT_LOAD: begin
                    lcd_rs   <= 1'b0;
                    lcd_data <= init_cmd(init_idx);
                    cnt      <= SETUP_LD;
                    state    <= ST_SETUP;
                end

                ST_SETUP: begin
                    if (cnt == '0) begin
                        lcd_e <= 1'b1;
                        cnt   <= E_LD;
                        state <= ST_E_HIGH;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                ST_E_HIGH: begin
                    if (cnt == '0) begin
                        lcd_e <= 1'b0;
                        cnt   <= HOLD_LD;
                        state <= ST_HOLD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                ST_HOLD: begin
                    if (cnt == '0) begin
                        cnt   <= is_clear_cmd ? CLEAR_LD : CMD_LD;
                        state <= ST_WAIT;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                ST_WAIT: begin
                    if (cnt == '0) begin
                        cur_pos <= pos_next;
                        if (!init_done) begin
                            if (init_idx == INIT_LAST) begin
                                init_done <= 1'b1;
                                wr_ready  <= 1'b1;
                                state     <= ST_IDLE;
                            end else begin
                                init_idx <= init_idx + 2'd1;
                                state    <= ST_INIT_LOAD;
                            end
                        end
`ifdef LCD_AUTOWRAP_EN
                        else if (wrap_next) begin
                            state <= ST_WRAP_LOAD;
                        end
`endif
                        else begin
                            wr_ready <= 1'b1;
                            state    <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                // Move to column 0 of the other line.
                ST_WRAP_LOAD: begin
                    lcd_rs   <= 1'b0;
                    lcd_data <= cur_pos[4] ? 8'h80 : 8'hC0;
                    cnt      <= SETUP_LD;
                    state    <= ST_SETUP;
                end

                ST_IDLE: begin
                    if (wr_valid && wr_ready) begin
                        wr_ready <= 1'b0;
                        lcd_rs   <= wr_rs;
                        lcd_data <= wr_data;
                        cnt      <= SETUP_LD;
                        state    <= ST_SETUP;
                    end
                end

                default: begin
                    lcd_e <= 1'b0;
                    state <= ST_POWERUP;
                    cnt   <= POWERUP_LD;
                end
            endcase
        end
    end

endmodule
